// File: rtl/mux_scan_serializer_if.sv
// Serial bit-stream handshake between mux_scan_serializer (master) and its consumer (slave).
interface mux_scan_serializer_if;
  logic ser_out;
  logic ser_valid;
  logic ser_ready;

  modport master (output ser_out, output ser_valid, input ser_ready);
  modport slave  (input ser_out, input ser_valid, output ser_ready);
endinterface

// File: rtl/mux_scan_serializer.sv
// Sequencer around an external 8:1 mux: holds a word on d, scans sel, streams y_in serially.
// Optional trailing even-parity beat when MUX_SCAN_PARITY_EN is defined.
module mux_scan_serializer #(
  parameter int unsigned SEL_W     = 3,
  parameter bit          LSB_FIRST = 1'b1,
  localparam int unsigned N        = 2 ** SEL_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [N-1:0]          data_in,
  output logic                  busy,
  output logic [N-1:0]          d,
  output logic [SEL_W-1:0]      sel,
  input  logic                  y_in,
  mux_scan_serializer_if.master ser,
  output logic                  done
);

`ifdef MUX_SCAN_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  localparam logic [SEL_W-1:0] START_IDX = LSB_FIRST ? '0 : '1;
  localparam logic [SEL_W-1:0] LAST_IDX  = LSB_FIRST ? '1 : '0;

  state_t           state;
  logic [SEL_W-1:0] sel_next;

  always_comb begin
    sel_next = LSB_FIRST ? sel + 1'b1 : sel - 1'b1;
  end

  // Data beats come straight from the mux; the parity beat bypasses it.
  always_comb begin
    ser.ser_out = y_in;
`ifdef MUX_SCAN_PARITY_EN
    if (state == PARITY) ser.ser_out = ^d;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      d             <= '0;
      sel           <= START_IDX;
      ser.ser_valid <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            d             <= data_in;
            sel           <= START_IDX;
            state         <= SHIFT;
            ser.ser_valid <= 1'b1;
            busy          <= 1'b1;
          end
        end
        SHIFT: begin
          if (ser.ser_valid && ser.ser_ready) begin
            if (sel == LAST_IDX) begin
`ifdef MUX_SCAN_PARITY_EN
              state <= PARITY;
`else
              state         <= IDLE;
              ser.ser_valid <= 1'b0;
              busy          <= 1'b0;
              done          <= 1'b1;
`endif
            end else begin
              sel <= sel_next;
            end
          end
        end
`ifdef MUX_SCAN_PARITY_EN
        PARITY: begin
          if (ser.ser_ready) begin
            state         <= IDLE;
            ser.ser_valid <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_serializer.sv
// Scoreboard bench for mux_scan_serializer: LSB-first and MSB-first instances share stimulus.
module tb_mux_scan_serializer;
  logic       clk = 1'b0;
  logic       rst, start, ser_ready;
  logic [7:0] data_in;

  always #5 clk = ~clk;

`ifdef MUX_SCAN_PARITY_EN
  localparam int BEATS = 9;
`else
  localparam int BEATS = 8;
`endif

  int total = 0;
  int bad   = 0;

  logic       a_busy, a_done, a_y, b_busy, b_done, b_y;
  logic [7:0] a_d, b_d;
  logic [2:0] a_sel, b_sel;

  mux_scan_serializer_if ifa();
  mux_scan_serializer_if ifb();
  assign ifa.ser_ready = ser_ready;
  assign ifb.ser_ready = ser_ready;

  // Behavioural 8:1 mux in front of each sequencer
  assign a_y = a_d[a_sel];
  assign b_y = b_d[b_sel];

  mux_scan_serializer #(.SEL_W(3), .LSB_FIRST(1'b1)) dut_a (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in), .busy(a_busy),
    .d(a_d), .sel(a_sel), .y_in(a_y), .ser(ifa), .done(a_done)
  );
  mux_scan_serializer #(.SEL_W(3), .LSB_FIRST(1'b0)) dut_b (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in), .busy(b_busy),
    .d(b_d), .sel(b_sel), .y_in(b_y), .ser(ifb), .done(b_done)
  );

  logic [7:0] qa[$];
  logic [7:0] qb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Beat k of a frame: {bit, sel}; beat 8 is the parity beat at the last index.
  function automatic logic [3:0] exp_beat(input bit lf, input logic [7:0] w, input int k);
    logic [2:0] idx;
    if (k >= 8) begin
      idx = lf ? 3'd7 : 3'd0;
      return {^w, idx};
    end
    idx = lf ? 3'(k) : 3'(7 - k);
    return {w[idx], idx};
  endfunction

  initial begin : mon_a
    int         k;
    logic       pend;
    logic [3:0] e;
    k = 0; pend = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        qa.delete(); k = 0; pend = 1'b0;
      end else begin
        chk("a_done", 32'(a_done), 32'(pend));
        pend = 1'b0;
        chk("a_busy", 32'(a_busy), 32'(qa.size() != 0));
        chk("a_valid", 32'(ifa.ser_valid), 32'(qa.size() != 0));
        if (qa.size() != 0) begin
          e = exp_beat(1'b1, qa[0], k);
          chk("a_sel", 32'(a_sel), 32'(e[2:0]));
          chk("a_bit", 32'(ifa.ser_out), 32'(e[3]));
          chk("a_d", 32'(a_d), 32'(qa[0]));
          if (ser_ready) begin
            k++;
            if (k == BEATS) begin
              void'(qa.pop_front()); k = 0; pend = 1'b1;
            end
          end
        end
      end
    end
  end

  initial begin : mon_b
    int         k;
    logic       pend;
    logic [3:0] e;
    k = 0; pend = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        qb.delete(); k = 0; pend = 1'b0;
      end else begin
        chk("b_done", 32'(b_done), 32'(pend));
        pend = 1'b0;
        chk("b_busy", 32'(b_busy), 32'(qb.size() != 0));
        chk("b_valid", 32'(ifb.ser_valid), 32'(qb.size() != 0));
        if (qb.size() != 0) begin
          e = exp_beat(1'b0, qb[0], k);
          chk("b_sel", 32'(b_sel), 32'(e[2:0]));
          chk("b_bit", 32'(ifb.ser_out), 32'(e[3]));
          chk("b_d", 32'(b_d), 32'(qb[0]));
          if (ser_ready) begin
            k++;
            if (k == BEATS) begin
              void'(qb.pop_front()); k = 0; pend = 1'b1;
            end
          end
        end
      end
    end
  end

  // A start is taken only if no frame is outstanding before the sampling edge.
  task automatic cyc(input logic r, input logic st, input logic [7:0] w, input logic rdy);
    logic acc;
    rst = r; start = st; data_in = w; ser_ready = rdy;
    acc = !r && st && (qa.size() == 0);
    @(posedge clk);
    #1;
    if (acc) begin
      qa.push_back(w);
      qb.push_back(w);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; data_in = '0; ser_ready = 1'b0;
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    chk("rst_a_d", 32'(a_d), 32'h0);
    chk("rst_a_sel", 32'(a_sel), 32'h0);
    chk("rst_b_sel", 32'(b_sel), 32'h7);
    chk("rst_busy", 32'(a_busy), 32'h0);
    chk("rst_valid", 32'(ifa.ser_valid), 32'h0);
    chk("rst_done", 32'(a_done), 32'h0);

    cyc(1'b0, 1'b1, 8'hA6, 1'b1);
    repeat (10) cyc(1'b0, 1'b0, 8'h00, 1'b1);
    cyc(1'b0, 1'b1, 8'h81, 1'b1);
    repeat (10) cyc(1'b0, 1'b0, 8'h00, 1'b1);

    cyc(1'b0, 1'b1, 8'hF0, 1'b1);
    for (int i = 0; i < 28; i++) cyc(1'b0, 1'b0, 8'h00, (i % 4 == 0) || (i % 4 == 3));
    repeat (12) cyc(1'b0, 1'b0, 8'h00, 1'b1);

    cyc(1'b0, 1'b1, 8'h3C, 1'b1);
    repeat (2) cyc(1'b0, 1'b0, 8'h00, 1'b1);
    cyc(1'b0, 1'b1, 8'hFF, 1'b1);
    repeat (10) cyc(1'b0, 1'b0, 8'h00, 1'b1);

    cyc(1'b0, 1'b1, 8'h5A, 1'b1);
    repeat (3) cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk("pre_rst_sel", 32'(a_sel), 32'h3);
    cyc(1'b1, 1'b0, 8'h00, 1'b1);
    chk("mid_rst_valid", 32'(ifa.ser_valid), 32'h0);
    repeat (3) cyc(1'b0, 1'b0, 8'h00, 1'b1);

    cyc(1'b0, 1'b1, 8'h07, 1'b1);
    repeat (11) cyc(1'b0, 1'b0, 8'h00, 1'b1);
    cyc(1'b0, 1'b1, 8'h03, 1'b1);
    repeat (11) cyc(1'b0, 1'b0, 8'h00, 1'b1);

    for (int i = 0; i < 400; i++)
      cyc(1'b0, $urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 3) != 0);

    for (int i = 0; i < 64 && qa.size() != 0; i++) cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk("drain_empty", 32'(qa.size()), 32'h0);
    repeat (2) cyc(1'b0, 1'b0, 8'h00, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
